rvfi_trace_buffer: RTL and testbench

RVFI_TRACE_BUFFER -- requirements
Module: rvfi_trace_buffer

---
 rtl/rvfi_trace_buffer.sv | 133 +++++++++++++
 tb/tb_rvfi_trace_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_buffer.sv
// Retirement trace buffer: captures one record per retired instruction into a FIFO
// and serialises each record as four 32-bit words; a new record reaches out_valid the cycle after capture.
// Backpressure: out_ready stalls the serialiser; a full FIFO drops records, counted and flagged via gap.
module rvfi_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] pc_rdata,
    input  logic [31:0] insn,
    input  logic [31:0] rd_wdata,
    input  logic [4:0]  rd_addr,
    input  logic [1:0]  mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [6:0]  level,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [6:0] FULL = 7'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [1:0]      idx;
    logic [31:0]     mem_pc   [DEPTH];
    logic [31:0]     mem_insn [DEPTH];
    logic [31:0]     mem_wd   [DEPTH];
    logic [31:0]     mem_meta [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [15:0]     seq;
    logic            pend_gap;

    logic            pop;
    logic            accept;
    logic [6:0]      level_pop;
    logic [6:0]      level_nxt;
    logic [31:0]     in_meta;
    logic [AW-1:0]   rd_ptr_nxt;
    logic [31:0]     head_w0;
    logic [31:0]     next_word;

    always_comb begin
        pop        = out_valid && out_ready && (idx == 2'd3);
        accept     = valid && ((level < FULL) || pop);
        level_pop  = level - {6'd0, pop};
        level_nxt  = level_pop + {6'd0, accept};
        in_meta    = {seq, 8'h00, pend_gap, mode, rd_addr};
        rd_ptr_nxt = rd_ptr + AW'(pop);
        // An empty FIFO (after any pop) means the only candidate head is the record arriving now
        head_w0    = (level_pop == 7'd0) ? pc_rdata : mem_pc[rd_ptr_nxt];
        next_word  = mem_meta[rd_ptr];
        if (idx == 2'd0)
            next_word = mem_insn[rd_ptr];
        else if (idx == 2'd1)
            next_word = mem_wd[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (accept && !reset) begin
            mem_pc[wr_ptr]   <= pc_rdata;
            mem_insn[wr_ptr] <= insn;
            mem_wd[wr_ptr]   <= rd_wdata;
            mem_meta[wr_ptr] <= in_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            seq        <= '0;
            pend_gap   <= 1'b0;
        end else begin
            if (valid)
                seq <= seq + 16'd1;
            if (accept) begin
                wr_ptr   <= wr_ptr + AW'(1);
                pend_gap <= 1'b0;
            end else if (valid) begin
                overflow <= 1'b1;
                pend_gap <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (state == IDLE) begin
            if (level_nxt != 7'd0) begin
                state     <= SEND;
                idx       <= 2'd0;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                out_data  <= head_w0;
            end
        end else if (out_ready) begin
            if (idx == 2'd3) begin
                idx      <= 2'd0;
                out_last <= 1'b0;
                if (level_nxt != 7'd0) begin
                    out_data <= head_w0;
                end else begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            end else begin
                idx      <= idx + 2'd1;
                out_data <= next_word;
                out_last <= (idx == 2'd2);
            end
        end
    end

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed bench for rvfi_trace_buffer with a word-level scoreboard checked on every handshake.
module tb_rvfi_trace_buffer;

    logic        clock;
    logic        reset;
    logic        valid;
    logic [31:0] pc_rdata;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [6:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] tb_seq = 16'd0;
    logic [32:0] q[$];

    rvfi_trace_buffer #(.DEPTH(8)) dut (
        .clock(clock), .reset(reset), .valid(valid), .pc_rdata(pc_rdata),
        .insn(insn), .rd_wdata(rd_wdata), .rd_addr(rd_addr), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .level(level), .overflow(overflow),
        .drop_count(drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one retirement; when accepted, queue its four expected words
    task automatic drive_rec(input logic [31:0] pc, input logic [31:0] in,
                             input logic [31:0] wd, input logic [4:0] rd,
                             input logic [1:0] md, input bit acc, input bit gap);
        valid    = 1'b1;
        pc_rdata = pc;
        insn     = in;
        rd_wdata = wd;
        rd_addr  = rd;
        mode     = md;
        if (acc) begin
            q.push_back({1'b0, pc});
            q.push_back({1'b0, in});
            q.push_back({1'b0, wd});
            q.push_back({1'b1, tb_seq, 8'h00, gap, md, rd});
        end
        tb_seq = tb_seq + 16'd1;
        step();
        valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            step();
            n++;
        end
        chk(tag, q.size(), 32'd0);
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed %h expected no word", out_data);
            end
            if (q.size() > 0) begin
                logic [32:0] e;
                e = q.pop_front();
                chk("word", out_data, e[31:0]);
                chk("last", {31'd0, out_last}, {31'd0, e[32]});
            end
        end
    end

    initial begin
        reset = 1'b1; valid = 1'b0; out_ready = 1'b0;
        pc_rdata = '0; insn = '0; rd_wdata = '0; rd_addr = '0; mode = '0;
        step();
        step();
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_out_last", out_last, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_level", level, 32'd0);
        chk("rst_overflow", overflow, 32'd0);
        chk("rst_drop_count", drop_count, 32'd0);
        reset = 1'b0;
        step();

        // Single record, free-flowing sink
        out_ready = 1'b1;
        drive_rec(32'h80000000, 32'h00500093, 32'h5, 5'd1, 2'd3, 1'b1, 1'b0);
        chk("lat_valid", out_valid, 32'd1);
        chk("lat_word0", out_data, 32'h80000000);
        wait_drain("drain_single");
        chk("single_idle_level", level, 32'd0);

        // Sink toggling ready every cycle: every word held until accepted
        out_ready = 1'b0;
        drive_rec(32'h00001000, 32'h12345678, 32'hCAFEF00D, 5'd31, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            logic [31:0] prev;
            logic        hold;
            out_ready = i[0];
            prev = out_data;
            hold = out_valid && !out_ready;
            step();
            if (hold) chk("hold_data", out_data, prev);
        end
        out_ready = 1'b1;
        wait_drain("drain_toggle");

        // Overflow: ten retirements into an eight-deep FIFO with a stalled sink
        reset = 1'b1;
        step();
        reset = 1'b0;
        tb_seq = 16'd0;
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            drive_rec(32'h2000 + 32'(i * 4), 32'h00000013 + 32'(i), 32'(i * 7), 5'(i), 2'(i), i < 8, 1'b0);
        chk("ovf_level", level, 32'd8);
        chk("ovf_flag", overflow, 32'd1);
        chk("ovf_drops", drop_count, 32'd2);
        out_ready = 1'b1;
        wait_drain("drain_ovf");
        drive_rec(32'h3000, 32'h00100073, 32'h0, 5'd0, 2'd3, 1'b1, 1'b1);
        wait_drain("drain_gap");
        chk("ovf_drops_after", drop_count, 32'd2);

        // Full FIFO with a word-3 pop and a retirement on the same edge
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            drive_rec(32'h4000 + 32'(i * 4), 32'hABCD0000 + 32'(i), 32'(i), 5'(i + 3), 2'd1, 1'b1, 1'b0);
        chk("full_level", level, 32'd8);
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("full_at_word3", out_last, 32'd1);
        drive_rec(32'h5000, 32'hDEADBEEF, 32'h77, 5'd9, 2'd2, 1'b1, 1'b0);
        chk("full_level_same", level, 32'd8);
        chk("full_drops_same", drop_count, 32'd2);
        wait_drain("drain_full");

        // Reset in the middle of a record
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            drive_rec(32'h6000 + 32'(i * 4), 32'h11110000 + 32'(i), 32'(i), 5'd4, 2'd0, 1'b1, 1'b0);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("mid_level", level, 32'd3);
        reset = 1'b1;
        valid = 1'b1;
        step();
        valid = 1'b0;
        reset = 1'b0;
        q.delete();
        chk("mid_rst_valid", out_valid, 32'd0);
        chk("mid_rst_level", level, 32'd0);
        chk("mid_rst_drops", drop_count, 32'd0);
        chk("mid_rst_ovf", overflow, 32'd0);
        tb_seq = 16'd0;
        out_ready = 1'b1;
        drive_rec(32'h7000, 32'h00000033, 32'h42, 5'd2, 2'd3, 1'b1, 1'b0);
        wait_drain("drain_after_rst");

        // Saturating drop counter and seq wrap
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            drive_rec(32'h8000 + 32'(i * 4), 32'h22220000 + 32'(i), 32'(i), 5'd5, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 65537; i++)
            drive_rec(32'h9000, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0);
        chk("sat_drops", drop_count, 32'h0000FFFF);
        chk("sat_ovf", overflow, 32'd1);
        chk("sat_level", level, 32'd8);
        out_ready = 1'b1;
        wait_drain("drain_sat");
        drive_rec(32'hA000, 32'h00000073, 32'h1, 5'd6, 2'd2, 1'b1, 1'b1);
        wait_drain("drain_wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
